// File: rtl/kgp_rf_pkg.sv
// Shared definitions for the register-file writeback scheduler:
// default widths, register count and the writeback request record.
package kgp_rf_pkg;
   localparam int DEFAULT_DATA_W = 32;
   localparam int DEFAULT_ADDR_W = 5;
   localparam int NUM_REGS       = 2 ** DEFAULT_ADDR_W;

   // Field is reg_idx because "reg" is a reserved word.
   typedef struct packed {
      logic [DEFAULT_ADDR_W-1:0] reg_idx;
      logic [DEFAULT_DATA_W-1:0] data;
   } wb_req_t;
endpackage

// File: rtl/rf_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, pointer remembers the last winner
// and only moves when a grant is actually issued.
module rf_rr_arb2
   import kgp_rf_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   output logic [1:0] grant
);
   // last_wb1_reg = 1 means wb1 won most recently, so wb0 has priority next.
   logic last_wb1_reg;
   logic last_wb1_next;

   always_comb begin
      grant = 2'b00;
      if (rst_n) begin
         grant[0] = req[0] & (~req[1] | last_wb1_reg);
         grant[1] = req[1] & (~req[0] | ~last_wb1_reg);
      end
      last_wb1_next = last_wb1_reg;
      if (|grant) begin
         last_wb1_next = grant[1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_wb1_reg <= 1'b1;
      end else begin
         last_wb1_reg <= last_wb1_next;
      end
   end
endmodule

// File: rtl/rf_wb_scheduler.sv
// Writeback scheduler: arbitrates ALU/load writebacks onto the single register
// file write port and tracks pending destination registers for decode stalls.
module rf_wb_scheduler
   import kgp_rf_pkg::*;
#(
   parameter int DATA_W = kgp_rf_pkg::DEFAULT_DATA_W,
   parameter int ADDR_W = kgp_rf_pkg::DEFAULT_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              claim_valid,
   input  logic [ADDR_W-1:0] claim_reg,
   input  logic              wb0_valid,
   input  logic [ADDR_W-1:0] wb0_reg,
   input  logic [DATA_W-1:0] wb0_data,
   output logic              wb0_ready,
   input  logic              wb1_valid,
   input  logic [ADDR_W-1:0] wb1_reg,
   input  logic [DATA_W-1:0] wb1_data,
   output logic              wb1_ready,
   output logic              rf_reg_write,
   output logic [ADDR_W-1:0] rf_write_register,
   output logic [DATA_W-1:0] rf_write_data,
   input  logic [ADDR_W-1:0] chk_reg_1,
   input  logic [ADDR_W-1:0] chk_reg_2,
   output logic              stall
);
   localparam int NREGS = 2 ** ADDR_W;

   logic [1:0]        grant;
   logic              accept;
   logic [ADDR_W-1:0] sel_reg;
   logic [DATA_W-1:0] sel_data;

   logic              rf_we_reg;
   logic [ADDR_W-1:0] rf_addr_reg;
   logic [DATA_W-1:0] rf_data_reg;

   logic [NREGS-1:0]  busy_reg;
   logic [NREGS-1:0]  busy_next;

   rf_rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   ({wb1_valid, wb0_valid}),
      .grant (grant)
   );

   assign wb0_ready = grant[0];
   assign wb1_ready = grant[1];
   assign accept    = |grant;
   assign sel_reg   = grant[1] ? wb1_reg  : wb0_reg;
   assign sel_data  = grant[1] ? wb1_data : wb0_data;

   // r0 writes are accepted to keep the pipeline moving but never reach the RF.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we_reg   <= 1'b0;
         rf_addr_reg <= '0;
         rf_data_reg <= '0;
      end else begin
         rf_we_reg <= accept && (sel_reg != '0);
         if (accept) begin
            rf_addr_reg <= sel_reg;
            rf_data_reg <= sel_data;
         end
      end
   end

   assign rf_reg_write      = rf_we_reg;
   assign rf_write_register = rf_addr_reg;
   assign rf_write_data     = rf_data_reg;

   // Set beats clear so a re-claim racing the previous commit stays pending.
   genvar gi;
   generate
      for (gi = 0; gi < NREGS; gi++) begin : g_busy
         if (gi == 0) begin : g_r0
            assign busy_next[gi] = 1'b0;
         end else begin : g_rn
            assign busy_next[gi] =
               (claim_valid && (claim_reg == ADDR_W'(gi))) ||
               (busy_reg[gi] && !(rf_we_reg && (rf_addr_reg == ADDR_W'(gi))));
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_reg <= '0;
      end else begin
         busy_reg <= busy_next;
      end
   end

   assign stall = rst_n & (busy_reg[chk_reg_1] | busy_reg[chk_reg_2]);
endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed bench for rf_wb_scheduler: a per-cycle vector table plus short
// hand-written sequences for contention after reset and mid-stream reset.
module tb_rf_wb_scheduler;
   import kgp_rf_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        claim_valid = 1'b0;
   logic [4:0]  claim_reg = '0;
   logic        wb0_valid = 1'b0;
   logic [4:0]  wb0_reg = '0;
   logic [31:0] wb0_data = '0;
   logic        wb0_ready;
   logic        wb1_valid = 1'b0;
   logic [4:0]  wb1_reg = '0;
   logic [31:0] wb1_data = '0;
   logic        wb1_ready;
   logic        rf_reg_write;
   logic [4:0]  rf_write_register;
   logic [31:0] rf_write_data;
   logic [4:0]  chk_reg_1 = '0;
   logic [4:0]  chk_reg_2 = '0;
   logic        stall;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   rf_wb_scheduler dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .claim_valid       (claim_valid),
      .claim_reg         (claim_reg),
      .wb0_valid         (wb0_valid),
      .wb0_reg           (wb0_reg),
      .wb0_data          (wb0_data),
      .wb0_ready         (wb0_ready),
      .wb1_valid         (wb1_valid),
      .wb1_reg           (wb1_reg),
      .wb1_data          (wb1_data),
      .wb1_ready         (wb1_ready),
      .rf_reg_write      (rf_reg_write),
      .rf_write_register (rf_write_register),
      .rf_write_data     (rf_write_data),
      .chk_reg_1         (chk_reg_1),
      .chk_reg_2         (chk_reg_2),
      .stall             (stall)
   );

   typedef struct {
      logic        cv;
      logic [4:0]  cr;
      logic        v0;
      wb_req_t     q0;
      logic        v1;
      wb_req_t     q1;
      logic [4:0]  c1;
      logic [4:0]  c2;
      logic        e_rdy0;
      logic        e_rdy1;
      logic        e_stall;
      logic        e_we;
      logic [4:0]  e_reg;
      logic [31:0] e_data;
   } vec_t;

   function automatic vec_t mk(logic cv, logic [4:0] cr,
                               logic v0, logic [4:0] a0, logic [31:0] d0,
                               logic v1, logic [4:0] a1, logic [31:0] d1,
                               logic [4:0] c1, logic [4:0] c2,
                               logic er0, logic er1, logic es, logic ew,
                               logic [4:0] ereg, logic [31:0] edata);
      vec_t v;
      v.cv = cv; v.cr = cr;
      v.v0 = v0; v.q0.reg_idx = a0; v.q0.data = d0;
      v.v1 = v1; v.q1.reg_idx = a1; v.q1.data = d1;
      v.c1 = c1; v.c2 = c2;
      v.e_rdy0 = er0; v.e_rdy1 = er1; v.e_stall = es; v.e_we = ew;
      v.e_reg = ereg; v.e_data = edata;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   // Drive one vector after the falling edge, check just after, then let the rising edge take it.
   task automatic run_vec(input vec_t v, input string tag);
      @(negedge clk);
      claim_valid = v.cv; claim_reg = v.cr;
      wb0_valid = v.v0; wb0_reg = v.q0.reg_idx; wb0_data = v.q0.data;
      wb1_valid = v.v1; wb1_reg = v.q1.reg_idx; wb1_data = v.q1.data;
      chk_reg_1 = v.c1; chk_reg_2 = v.c2;
      #1;
      check({tag, ".wb0_ready"}, 32'(wb0_ready), 32'(v.e_rdy0));
      check({tag, ".wb1_ready"}, 32'(wb1_ready), 32'(v.e_rdy1));
      check({tag, ".stall"}, 32'(stall), 32'(v.e_stall));
      check({tag, ".rf_we"}, 32'(rf_reg_write), 32'(v.e_we));
      check({tag, ".rf_reg"}, 32'(rf_write_register), 32'(v.e_reg));
      check({tag, ".rf_data"}, rf_write_data, v.e_data);
      $display("vec %s: rdy=%b%b stall=%b we=%b reg=%0d data=0x%08h",
               tag, wb1_ready, wb0_ready, stall, rf_reg_write, rf_write_register, rf_write_data);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      wb0_valid = 1'b1; wb0_reg = 5'd6; wb0_data = 32'h6;
      wb1_valid = 1'b1; wb1_reg = 5'd7; wb1_data = 32'h7;
      #1;
      check("rst.wb0_ready", 32'(wb0_ready), 32'd0);
      check("rst.wb1_ready", 32'(wb1_ready), 32'd0);
      check("rst.stall", 32'(stall), 32'd0);
      check("rst.rf_we", 32'(rf_reg_write), 32'd0);
      check("rst.rf_reg", 32'(rf_write_register), 32'd0);
      check("rst.rf_data", rf_write_data, 32'd0);
      $display("reset: checked outputs held low");
      repeat (2) @(negedge clk);
      wb0_valid = 1'b0; wb1_valid = 1'b0; claim_valid = 1'b0;
      rst_n = 1'b1;
   endtask

   vec_t tbl[24];
   vec_t seq[6];

   initial begin
      // cv cr  v0 a0 d0   v1 a1 d1   c1 c2   rdy0 rdy1 stall we reg data
      tbl[0]  = mk(0,0, 0,0,0, 0,0,0, 0,0, 0,0,0,0, 0,32'h0);
      tbl[1]  = mk(0,0, 1,3,32'hAA, 0,0,0, 0,0, 1,0,0,0, 0,32'h0);
      tbl[2]  = mk(0,0, 0,0,0, 0,0,0, 0,0, 0,0,0,1, 3,32'hAA);
      tbl[3]  = mk(0,0, 1,4,32'h44, 1,5,32'h55, 0,0, 0,1,0,0, 3,32'hAA);
      tbl[4]  = mk(0,0, 1,4,32'h44, 1,5,32'h55, 0,0, 1,0,0,1, 5,32'h55);
      tbl[5]  = mk(0,0, 1,4,32'h44, 1,5,32'h55, 0,0, 0,1,0,1, 4,32'h44);
      tbl[6]  = mk(0,0, 1,4,32'h44, 1,5,32'h55, 0,0, 1,0,0,1, 5,32'h55);
      tbl[7]  = mk(0,0, 0,0,0, 0,0,0, 0,0, 0,0,0,1, 4,32'h44);
      tbl[8]  = mk(0,0, 0,0,0, 0,0,0, 0,0, 0,0,0,0, 4,32'h44);
      tbl[9]  = mk(1,7, 0,0,0, 0,0,0, 7,0, 0,0,0,0, 4,32'h44);
      tbl[10] = mk(0,0, 0,0,0, 0,0,0, 7,0, 0,0,1,0, 4,32'h44);
      tbl[11] = mk(0,0, 0,0,0, 0,0,0, 7,0, 0,0,1,0, 4,32'h44);
      tbl[12] = mk(0,0, 0,0,0, 1,7,32'h77, 7,0, 0,1,1,0, 4,32'h44);
      tbl[13] = mk(0,0, 0,0,0, 0,0,0, 7,0, 0,0,1,1, 7,32'h77);
      tbl[14] = mk(0,0, 0,0,0, 0,0,0, 7,0, 0,0,0,0, 7,32'h77);
      tbl[15] = mk(1,9, 1,9,32'h99, 0,0,0, 0,9, 1,0,0,0, 7,32'h77);
      tbl[16] = mk(1,9, 0,0,0, 0,0,0, 0,9, 0,0,1,1, 9,32'h99);
      tbl[17] = mk(0,0, 0,0,0, 0,0,0, 0,9, 0,0,1,0, 9,32'h99);
      tbl[18] = mk(0,0, 0,0,0, 1,9,32'h199, 0,9, 0,1,1,0, 9,32'h99);
      tbl[19] = mk(0,0, 0,0,0, 0,0,0, 0,9, 0,0,1,1, 9,32'h199);
      tbl[20] = mk(0,0, 0,0,0, 0,0,0, 0,9, 0,0,0,0, 9,32'h199);
      tbl[21] = mk(1,0, 1,0,32'hFFFF_FFFF, 0,0,0, 0,0, 1,0,0,0, 9,32'h199);
      tbl[22] = mk(0,0, 0,0,0, 0,0,0, 0,0, 0,0,0,0, 0,32'hFFFF_FFFF);
      tbl[23] = mk(0,0, 0,0,0, 0,0,0, 0,0, 0,0,0,0, 0,32'hFFFF_FFFF);

      // Fresh reset: wb0 wins the first contended cycle, then strict alternation.
      seq[0] = mk(0,0, 1,4,32'h44, 1,5,32'h55, 0,0, 1,0,0,0, 0,32'h0);
      seq[1] = mk(0,0, 1,4,32'h44, 1,5,32'h55, 0,0, 0,1,0,1, 4,32'h44);
      seq[2] = mk(0,0, 1,4,32'h44, 1,5,32'h55, 0,0, 1,0,0,1, 5,32'h55);
      seq[3] = mk(0,0, 1,4,32'h44, 1,5,32'h55, 0,0, 0,1,0,1, 4,32'h44);
      seq[4] = mk(0,0, 0,0,0, 0,0,0, 0,0, 0,0,0,1, 5,32'h55);
      seq[5] = mk(0,0, 0,0,0, 0,0,0, 0,0, 0,0,0,0, 5,32'h55);

      do_reset();
      for (int i = 0; i < 24; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

      do_reset();
      for (int i = 0; i < 6; i++) run_vec(seq[i], $sformatf("rr%0d", i));

      // Mid-stream reset with r2 busy and a write pending on the output register.
      run_vec(mk(1,2, 0,0,0, 0,0,0, 2,0, 0,0,0,0, 5,32'h55), "mr0");
      run_vec(mk(0,0, 1,5,32'h1234, 0,0,0, 2,0, 1,0,1,0, 5,32'h55), "mr1");
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mr.rf_we_at_reset", 32'(rf_reg_write), 32'd0);
      check("mr.stall_at_reset", 32'(stall), 32'd0);
      check("mr.wb0_ready_at_reset", 32'(wb0_ready), 32'd0);
      check("mr.rf_data_at_reset", rf_write_data, 32'd0);
      $display("midreset: we=%b stall=%b rdy0=%b", rf_reg_write, stall, wb0_ready);
      @(negedge clk);
      wb0_valid = 1'b0;
      rst_n = 1'b1;
      run_vec(mk(0,0, 0,0,0, 0,0,0, 2,2, 0,0,0,0, 0,32'h0), "mr2");
      run_vec(mk(0,0, 0,0,0, 0,0,0, 2,2, 0,0,0,0, 0,32'h0), "mr3");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/rf_wb_scheduler.md
RF_WB_SCHEDULER -- requirements
Module: rf_wb_scheduler

Interface
REQ-001 Parameter DATA_W, default 32, width of register data.
REQ-002 Parameter ADDR_W, default 5, register index width (2**ADDR_W registers).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-004 claim_valid input 1: issue stage marks claim_reg as pending-write this cycle.
REQ-005 claim_reg input ADDR_W: destination register being claimed.
REQ-006 wb0_valid input 1, wb0_reg input ADDR_W, wb0_data input DATA_W: ALU writeback request.
REQ-007 wb0_ready output 1: wb0 request accepted this cycle.
REQ-008 wb1_valid input 1, wb1_reg input ADDR_W, wb1_data input DATA_W: load-unit writeback request.
REQ-009 wb1_ready output 1: wb1 request accepted this cycle.
REQ-010 rf_reg_write output 1, rf_write_register output ADDR_W, rf_write_data output DATA_W: drive the register-file write port.
REQ-011 chk_reg_1 input ADDR_W, chk_reg_2 input ADDR_W: source registers of the instruction in decode.
REQ-012 stall output 1: a checked source register has a pending write.

Function
REQ-013 At most one writeback SHALL be accepted per cycle; wbN_ready SHALL be high only when wbN_valid is high and port N holds the grant (combinational from valids and arbiter state).
REQ-014 Arbitration SHALL be two-way round-robin: a single requester always wins; when both are valid, the port not granted most recently wins; the pointer updates only on an accept.
REQ-015 An accepted request at cycle T SHALL appear on rf_reg_write/rf_write_register/rf_write_data in cycle T+1 (registered outputs, 1-cycle latency); rf_reg_write SHALL be low in any cycle following a cycle with no accept.
REQ-016 A request with wbN_reg = 0 SHALL be accepted normally but SHALL NOT assert rf_reg_write (r0 writes discarded).
REQ-017 A scoreboard of 2**ADDR_W busy bits SHALL be kept; bit r is set on the edge ending a cycle with claim_valid and claim_reg = r.
REQ-018 Busy bit r SHALL clear on the edge ending a cycle with rf_reg_write high and rf_write_register = r, coinciding with the register-file write.
REQ-019 Simultaneous set and clear of the same bit: set wins (bit stays busy).
REQ-020 Clearing a non-busy bit SHALL have no effect and no error; claim_reg = 0 SHALL never set a busy bit.
REQ-021 stall SHALL equal busy[chk_reg_1] OR busy[chk_reg_2], combinational from registered busy state only (no bypass from same-cycle claim or write).
REQ-022 Held wbN_valid with stable payload SHALL be accepted within 2 cycles when the other port is continuously valid (no starvation).

Reset
REQ-023 On rst_n low, asynchronously: rf_reg_write = 0, rf_write_register = 0, rf_write_data = 0, all busy bits = 0, round-robin pointer = "wb1 last", so wb0 wins the first contended cycle.
REQ-024 While rst_n is low, wb0_ready, wb1_ready and stall SHALL be 0; a request in flight at reset assertion is dropped, not replayed.
REQ-025 Reset deassertion SHALL be synchronised externally; the first accept is possible in the first cycle after release.

Structure
REQ-026 Shared package kgp_rf_pkg SHALL hold DATA_W/ADDR_W defaults, NUM_REGS, and the writeback-request struct type {reg, data}.
REQ-027 Arbitration SHALL be a sub-module rf_rr_arb2 (two requests in, one-hot grant out, pointer update on accept); scoreboard and output register remain in the top.

Verification
REQ-028 After reset, wb0 valid reg=3 data=0x0000_00AA alone -> wb0_ready=1 at T; T+1 rf_reg_write=1, register 3, data 0xAA.
REQ-029 wb0 and wb1 both valid 4 cycles (regs 4,5) -> grants wb0,wb1,wb0,wb1; RF writes in that order, each one cycle later.
REQ-030 Claim reg 7 at T; chk_reg_1=7 -> stall=1 from T+1; wb1 writes r7 at T+3 -> rf_reg_write at T+4, stall=0 at T+5.
REQ-031 Claim r9 and commit r9 in same cycle -> busy[9] remains 1, stall on chk_reg_2=9 persists until next commit of r9.
REQ-032 wb0 reg=0 data=0xFFFF_FFFF -> wb0_ready=1, rf_reg_write stays 0; claim r0 -> stall never asserts.
REQ-033 Assert rst_n low mid-stream with busy r2 and pending output -> rf_reg_write=0, stall=0 immediately; no write of pending data after release.
